// File: rtl/tlul_host_port.sv
// tlul_host_port: simple req/gnt host to TL-UL initiator bridge.
// Tracks up to MAX_REQS in-order outstanding transactions, hands out source IDs
// round-robin and flags responses whose source/opcode do not match.
// Optional response timeout: define TLUL_HOST_TIMEOUT_EN.
module tlul_host_port #(
  parameter int unsigned MAX_REQS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_i,
  output logic         gnt_o,
  input  logic [31:0]  addr_i,
  input  logic         we_i,
  input  logic [31:0]  wdata_i,
  input  logic [3:0]   be_i,
  output logic         valid_o,
  output logic [31:0]  rdata_o,
  output logic         err_o,
  output logic         proto_err_o,
  output logic [101:0] tl_o,
  input  logic [67:0]  tl_i
);

  localparam int unsigned PW = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
  localparam int unsigned CW = $clog2(MAX_REQS + 1);

  logic [PW-1:0]       iptr_q, iptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [MAX_REQS-1:0] is_read_q;
  logic                proto_q, proto_d;

  // D-channel field decode
  logic        d_valid_s, d_error_s, a_ready_s;
  logic [2:0]  d_opcode_s;
  logic [7:0]  d_source_s;
  logic [31:0] d_data_s;
  assign d_valid_s  = tl_i[67];
  assign d_opcode_s = tl_i[66:64];
  assign d_source_s = tl_i[58:51];
  assign d_data_s   = tl_i[49:18];
  assign d_error_s  = tl_i[1];
  assign a_ready_s  = tl_i[0];

  // d_param, d_size, d_sink, d_user and the byte offset carry nothing we act on
  logic unused_s;
  assign unused_s = ^{tl_i[63:59], tl_i[50], tl_i[17:2], addr_i[1:0]};

  logic empty_s, full_s, a_valid_s, gnt_s;
  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign full_s    = (cnt_q == CW'(MAX_REQS));
  assign a_valid_s = req_i & ~full_s;
  assign gnt_s     = a_valid_s & a_ready_s;

  logic [7:0] rsrc_s;
  logic [2:0] exp_op_s;
  logic       src_mm_s, op_mm_s, mismatch_s, rsp_retire_s, retire_s, to_fire_s;
  assign rsrc_s       = {{(8-PW){1'b0}}, rptr_q};
  assign exp_op_s     = is_read_q[rptr_q] ? 3'd1 : 3'd0;
  assign src_mm_s     = (d_source_s != rsrc_s);
  assign op_mm_s      = (d_opcode_s != exp_op_s);
  // Empty means nothing can legitimately match, regardless of ID/opcode
  assign mismatch_s   = src_mm_s | op_mm_s | empty_s;
  assign rsp_retire_s = d_valid_s & ~empty_s;
  assign retire_s     = rsp_retire_s | to_fire_s;

`ifdef TLUL_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // A real response in the same cycle always pre-empts the timeout
  assign to_fire_s = ~d_valid_s & ~empty_s & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Timeout counter runs only while waiting on an outstanding response
  always_comb begin
    tcnt_d = tcnt_q;
    if (d_valid_s || empty_s || to_fire_s) begin
      tcnt_d = {TW{1'b0}};
    end else begin
      tcnt_d = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Timeout counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= {TW{1'b0}};
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign rdata_o = to_fire_s ? 32'hFFFF_FFFF : d_data_s;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_fire_s = 1'b0;
  assign rdata_o   = d_data_s;
`endif

  assign valid_o     = d_valid_s | to_fire_s;
  assign err_o       = (d_valid_s & (d_error_s | mismatch_s)) | to_fire_s;
  assign gnt_o       = gnt_s;
  assign proto_err_o = proto_q;

  // A-channel payload; fields are held at zero while no request is presented
  logic [2:0]  a_opcode_s;
  logic [3:0]  a_mask_s;
  logic [31:0] a_data_s;
  always_comb begin
    a_opcode_s = 3'd0;
    a_mask_s   = 4'h0;
    a_data_s   = 32'h0;
    if (!a_valid_s) begin
      a_opcode_s = 3'd0;
    end else if (!we_i) begin
      a_opcode_s = 3'd4;
      a_mask_s   = 4'hF;
    end else begin
      a_opcode_s = (be_i == 4'hF) ? 3'd0 : 3'd1;
      a_mask_s   = be_i;
      a_data_s   = wdata_i;
    end
  end

  assign tl_o = {a_valid_s,
                 a_opcode_s,
                 3'd0,
                 a_valid_s ? 2'd2 : 2'd0,
                 a_valid_s ? {{(8-PW){1'b0}}, iptr_q} : 8'd0,
                 a_valid_s ? {addr_i[31:2], 2'b00} : 32'd0,
                 a_mask_s,
                 a_data_s,
                 16'd0,
                 1'b1};

  // Next-state for pointers, outstanding count and sticky protocol flag
  always_comb begin
    iptr_d  = iptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    proto_d = proto_q | (d_valid_s & mismatch_s) | to_fire_s;
    if (gnt_s) begin
      iptr_d = (iptr_q == PW'(MAX_REQS - 1)) ? {PW{1'b0}} : iptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      iptr_d = iptr_q;
    end
    if (retire_s) begin
      rptr_d = (rptr_q == PW'(MAX_REQS - 1)) ? {PW{1'b0}} : rptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
    if (gnt_s && !retire_s) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (!gnt_s && retire_s) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers, including per-slot read/write record written on grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iptr_q    <= {PW{1'b0}};
      rptr_q    <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      proto_q   <= 1'b0;
      is_read_q <= {MAX_REQS{1'b0}};
    end else begin
      iptr_q  <= iptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      proto_q <= proto_d;
      if (gnt_s) begin
        is_read_q[iptr_q] <= ~we_i;
      end
    end
  end

endmodule

// File: tb/tb_tlul_host_port.sv
// Directed self-checking bench for tlul_host_port (MAX_REQS = 2).
module tb_tlul_host_port;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_i = 1'b0;
  logic         gnt_o;
  logic [31:0]  addr_i = 32'h0;
  logic         we_i = 1'b0;
  logic [31:0]  wdata_i = 32'h0;
  logic [3:0]   be_i = 4'h0;
  logic         valid_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic         proto_err_o;
  logic [101:0] tl_o;
  logic [67:0]  tl_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlul_host_port #(
    .MAX_REQS(2),
`ifdef TLUL_HOST_TIMEOUT_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(1024)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o),
    .proto_err_o(proto_err_o), .tl_o(tl_o), .tl_i(tl_i)
  );

  function automatic logic [67:0] d2h(input logic v, input logic [2:0] op,
                                      input logic [7:0] src, input logic [31:0] data,
                                      input logic derr);
    d2h = {v, op, 3'd0, 2'd2, src, 1'b0, data, 16'd0, derr, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [101:0] obs, input logic [101:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b);
    req_i = r; we_i = w; addr_i = a; wdata_i = wd; be_i = b;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] op, input logic [7:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    chk({tag, ".gnt"},  102'(gnt_o), 102'd1);
    chk({tag, ".a"}, tl_o, {1'b1, op, 3'd0, 2'd2, src, addr, mask, data, 16'd0, 1'b1});
  endtask

  task automatic chk_d(input string tag, input logic v, input logic e, input logic [31:0] rd);
    chk({tag, ".valid"}, 102'(valid_o), 102'(v));
    chk({tag, ".err"},   102'(err_o),   102'(e));
    chk({tag, ".rdata"}, 102'(rdata_o), 102'(rd));
  endtask

  initial begin
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
    #1;
    // reset state
    chk("rst.tl_o", tl_o, {101'd0, 1'b1});
    chk("rst.gnt", 102'(gnt_o), 102'd0);
    chk("rst.valid", 102'(valid_o), 102'd0);
    chk("rst.proto", 102'(proto_err_o), 102'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // read with unaligned address
    set_req(1'b1, 1'b0, 32'h1000_0007, 32'h0, 4'h0);
    #1;
    chk_a("rd0", 3'd4, 8'd0, 32'h1000_0004, 4'hF, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tl_i = d2h(1'b1, 3'd1, 8'd0, 32'hDEAD_BEEF, 1'b0);
    #1;
    chk_d("rd0.rsp", 1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
    #1;
    chk("rd0.proto", 102'(proto_err_o), 102'd0);

    // fresh reset so the write sequence starts at source 0
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; tick();

    set_req(1'b1, 1'b1, 32'h2000_0000, 32'h1122_3344, 4'hF);
    #1;
    chk_a("wrF", 3'd0, 8'd0, 32'h2000_0000, 4'hF, 32'h1122_3344);
    tick();
    set_req(1'b1, 1'b1, 32'h2000_0010, 32'h5566_7788, 4'h3);
    #1;
    chk_a("wr3", 3'd1, 8'd1, 32'h2000_0010, 4'h3, 32'h5566_7788);
    tick();
    // full: request held, response to slot 0 arrives in the same cycle
    set_req(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0);
    tl_i = d2h(1'b1, 3'd0, 8'd0, 32'h0, 1'b0);
    #1;
    chk("full.gnt", 102'(gnt_o), 102'd0);
    chk("full.avalid", 102'(tl_o[101]), 102'd0);
    chk_d("wrF.rsp", 1'b1, 1'b0, 32'h0);
    tick();
    // grant (source wraps to 0) together with response to slot 1
    tl_i = d2h(1'b1, 3'd0, 8'd1, 32'h0, 1'b0);
    #1;
    chk_a("wrap", 3'd4, 8'd0, 32'h3000_0000, 4'hF, 32'h0);
    chk_d("wr3.rsp", 1'b1, 1'b0, 32'h0);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
    #1;
    chk_a("rd2", 3'd4, 8'd1, 32'h3000_0000, 4'hF, 32'h0);
    tick();
    // two outstanding again: the same-cycle grant/retire kept the count at one
    #1;
    chk("full2.gnt", 102'(gnt_o), 102'd0);
    chk("wr.proto", 102'(proto_err_o), 102'd0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // source mismatch (expects 0), then opcode mismatch on a read slot
    tl_i = d2h(1'b1, 3'd1, 8'd1, 32'h0000_00AA, 1'b0);
    #1;
    chk_d("srcmm", 1'b1, 1'b1, 32'h0000_00AA);
    tick();
    chk("srcmm.proto", 102'(proto_err_o), 102'd1);
    tl_i = d2h(1'b1, 3'd0, 8'd1, 32'h0, 1'b0);
    #1;
    chk_d("opmm", 1'b1, 1'b1, 32'h0);
    tick();
    // unsolicited response with nothing outstanding
    tl_i = d2h(1'b1, 3'd1, 8'd0, 32'h0000_0055, 1'b0);
    #1;
    chk_d("unsol", 1'b1, 1'b1, 32'h0000_0055);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
    // pointers untouched: next grant uses source 0 and a source-0 reply is clean
    set_req(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    #1;
    chk_a("post", 3'd4, 8'd0, 32'h4000_0000, 4'hF, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tl_i = d2h(1'b1, 3'd1, 8'd0, 32'hCAFE_F00D, 1'b0);
    #1;
    chk_d("post.rsp", 1'b1, 1'b0, 32'hCAFE_F00D);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
    #1;
    chk("sticky.proto", 102'(proto_err_o), 102'd1);

    // device error on a matching response
    set_req(1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tl_i = d2h(1'b1, 3'd1, 8'd1, 32'h0, 1'b1);
    #1;
    chk_d("derr", 1'b1, 1'b1, 32'h0);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);

    // reset mid-transaction, then a late response
    set_req(1'b1, 1'b0, 32'h6000_0000, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_ni = 1'b0;
    #1;
    chk("midrst.proto", 102'(proto_err_o), 102'd0);
    chk("midrst.tl_o", tl_o, {101'd0, 1'b1});
    tick();
    rst_ni = 1'b1;
    tl_i = d2h(1'b1, 3'd1, 8'd0, 32'h0, 1'b0);
    #1;
    chk_d("late", 1'b1, 1'b1, 32'h0);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);

`ifdef TLUL_HOST_TIMEOUT_EN
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; tick();
    set_req(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'h0);
    #1;
    chk_a("to.rd", 3'd4, 8'd0, 32'h7000_0000, 4'hF, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("to.wait", 102'(valid_o), 102'd0);
      tick();
    end
    #1;
    chk_d("to.fire", 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    chk("to.proto", 102'(proto_err_o), 102'd1);
    chk("to.idle", 102'(valid_o), 102'd0);
    // slot retired: next grant gets source 1 and its source-1 reply is clean
    set_req(1'b1, 1'b0, 32'h7000_0004, 32'h0, 4'h0);
    #1;
    chk_a("to.next", 3'd4, 8'd1, 32'h7000_0004, 4'hF, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tl_i = d2h(1'b1, 3'd1, 8'd1, 32'h1234_5678, 1'b0);
    #1;
    chk_d("to.next.rsp", 1'b1, 1'b0, 32'h1234_5678);
    tick();
    tl_i = d2h(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
